// File: rtl/mage_stream_buffer.sv
// Per-channel elastic stream buffer: small FIFO plus a length-programmed transfer FSM that tags the last element.
// Optional stall statistics are built when MAGE_STREAM_BUF_STATS_EN is defined.
module mage_stream_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [CNT_W-1:0]           cfg_len_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_last_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CNT_W-1:0]           stall_in_o,
  output logic [CNT_W-1:0]           stall_out_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [AW:0]       count_q;
  logic [CNT_W-1:0]  len_q, in_cnt_q, out_cnt_q;
  logic              done_q;
  logic              full, empty, push, pop, start_ok;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on the same-cycle valid/ready of the opposite side.
  assign full        = (count_q == FULL_LVL);
  assign empty       = (count_q == '0);
  assign in_ready_o  = (state_q == S_RUN) && !full && (in_cnt_q < len_q);
  assign out_valid_o = !empty;
  assign out_data_o  = mem[rd_ptr_q];
  assign out_last_o  = out_valid_o && (out_cnt_q == len_q - CNT_W'(1));
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign start_ok    = start_i && (state_q == S_IDLE);
  assign level_o     = count_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      // Abort keeps memory contents; only bookkeeping is cleared.
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) begin
        mem[wr_ptr_q] <= in_data_i;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        out_cnt_q <= out_cnt_q + CNT_W'(1);
      end
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_q     <= cfg_len_i;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            if (cfg_len_i != '0) state_q <= S_RUN;
            else                 done_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (push) begin
            in_cnt_q <= in_cnt_q + CNT_W'(1);
            if (in_cnt_q + CNT_W'(1) == len_q) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && (out_cnt_q == len_q - CNT_W'(1))) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MAGE_STREAM_BUF_STATS_EN
  logic [CNT_W-1:0] stall_in_q, stall_out_q;

  // Saturating stall counters, restarted with every accepted transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || start_ok) begin
      stall_in_q  <= '0;
      stall_out_q <= '0;
    end else begin
      if ((state_q == S_RUN) && in_valid_i && !in_ready_o && (stall_in_q != '1))
        stall_in_q <= stall_in_q + CNT_W'(1);
      if (out_valid_o && !out_ready_i && (stall_out_q != '1))
        stall_out_q <= stall_out_q + CNT_W'(1);
    end
  end

  assign stall_in_o  = stall_in_q;
  assign stall_out_o = stall_out_q;
`else
  assign stall_in_o  = '0;
  assign stall_out_o = '0;
`endif

endmodule

// File: tb/tb_mage_stream_buffer.sv
// Directed and randomized checks of mage_stream_buffer against a queue-based transfer model.
module tb_mage_stream_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, start, flush, in_valid, out_ready;
  logic [CNT_W-1:0]  cfg_len;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid, out_last, busy, done;
  logic [DATA_W-1:0] out_data;
  logic [LW-1:0]     level;
  logic [CNT_W-1:0]  stall_in, stall_out;

  mage_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_len_i(cfg_len), .flush_i(flush),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
    .out_ready_i(out_ready), .level_o(level), .busy_o(busy), .done_o(done),
    .stall_in_o(stall_in), .stall_out_o(stall_out)
  );

  always #5 clk = ~clk;

  int total = 0, passes = 0, fails = 0;

  // Reference model: expected FIFO contents plus transfer bookkeeping.
  logic [DATA_W-1:0] exp_q[$];
  bit                m_busy = 0, m_done = 0;
  int                m_len = 0, m_pushed = 0, m_popped = 0;
  int                m_stall_in = 0, m_stall_out = 0;
  logic [DATA_W-1:0] next_data = '0;
  bit                rand_data = 0;
  int                busy_seen = 0, done_seen = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit e_run = m_busy && (m_pushed < m_len);
    bit e_ir  = e_run && (exp_q.size() < DEPTH);
    bit e_ov  = exp_q.size() > 0;
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (e_ov) chk("out_data", out_data, exp_q[0]);
    chk("out_last", 32'(out_last), 32'(e_ov && (m_popped == m_len - 1)));
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
`ifdef MAGE_STREAM_BUF_STATS_EN
    chk("stall_in", 32'(stall_in), 32'(m_stall_in));
    chk("stall_out", 32'(stall_out), 32'(m_stall_out));
`else
    chk("stall_in", 32'(stall_in), 32'd0);
    chk("stall_out", 32'(stall_out), 32'd0);
`endif
    if (busy === 1'b1) busy_seen++;
    if (done === 1'b1) done_seen++;
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic step(bit iv, bit ordy, bit st, int len, bit fl);
    bit e_run, e_ir, e_ov, push, pop, was_busy;
    @(negedge clk);
    in_valid  = iv;
    in_data   = next_data;
    out_ready = ordy;
    start     = st;
    cfg_len   = CNT_W'(len);
    flush     = fl;
    #1;
    check_outputs();
    e_run    = m_busy && (m_pushed < m_len);
    e_ir     = e_run && (exp_q.size() < DEPTH);
    e_ov     = exp_q.size() > 0;
    push     = iv && e_ir;
    pop      = e_ov && ordy;
    was_busy = m_busy;
    @(posedge clk);
    m_done = 0;
    if (e_run && iv && !e_ir && m_stall_in < 65535) m_stall_in++;
    if (e_ov && !ordy && m_stall_out < 65535) m_stall_out++;
    if (fl) begin
      exp_q.delete();
      m_busy = 0; m_pushed = 0; m_popped = 0;
      m_stall_in = 0; m_stall_out = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_popped++;
        if (m_busy && m_popped == m_len) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (push) begin
        exp_q.push_back(next_data);
        m_pushed++;
        next_data = rand_data ? $urandom : next_data + 1;
      end
      if (st && !was_busy) begin
        m_len = len; m_pushed = 0; m_popped = 0;
        m_stall_in = 0; m_stall_out = 0;
        if (len == 0) m_done = 1;
        else          m_busy = 1;
      end
    end
  endtask

  task automatic run_to_idle(int pv, int pr, int max_cycles, string tag);
    int n = 0;
    while (m_busy && n < max_cycles) begin
      step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr, 0, 0, 0);
      n++;
    end
    chk(tag, 32'(n < max_cycles), 32'd1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
  endtask

  initial begin
    rst = 1; start = 0; flush = 0; in_valid = 0; out_ready = 0; cfg_len = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_out_data", out_data, 32'd0);
    check_outputs();

    // Basic transfer: A0..A4, sink always ready.
    busy_seen = 0; done_seen = 0; next_data = 32'hA0;
    step(0, 1, 1, 5, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    chk("basic_busy_cycles", 32'(busy_seen), 32'd6);
    chk("basic_done_count", 32'(done_seen), 32'd1);

    // Back-pressure: sink stalled for 10 cycles, source always offering.
    next_data = 32'hB0;
    step(0, 0, 1, 8, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    chk("bp_level_full", 32'(level), 32'd4);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    run_to_idle(100, 100, 50, "bp_timeout");

    // Zero length.
    busy_seen = 0; done_seen = 0;
    step(0, 1, 1, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    chk("zero_busy_cycles", 32'(busy_seen), 32'd0);
    chk("zero_done_count", 32'(done_seen), 32'd1);

    // Wrap-around with random valid/ready and data.
    rand_data = 1; next_data = $urandom;
    for (int r = 0; r < 4; r++) begin
      step(0, 0, 1, 13, 0);
      run_to_idle(50, 50, 400, "wrap_timeout");
    end

    // Flush mid-transfer after 3 pushes and 1 pop.
    rand_data = 0; next_data = 32'hC0; done_seen = 0;
    step(0, 0, 1, 10, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 3, 1);
    step(0, 0, 0, 0, 0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done_count", 32'(done_seen), 32'd0);
    step(0, 0, 1, 2, 0);
    run_to_idle(100, 100, 50, "flush_restart_timeout");
    chk("flush_restart_done", 32'(done_seen), 32'd1);

    // Start while busy is ignored.
    next_data = 32'hD0; done_seen = 0;
    step(0, 1, 1, 6, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 3, 0);
    run_to_idle(70, 70, 100, "busy_start_timeout");
    chk("busy_start_done_count", 32'(done_seen), 32'd1);
    chk("busy_start_len", 32'(m_popped), 32'd6);

    // Random mix including stalls and flushes.
    rand_data = 1;
    for (int r = 0; r < 6; r++) begin
      step(0, 0, 1, $urandom_range(1, 9), 0);
      for (int c = 0; c < 8; c++) step($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
      if (r % 3 == 2) step(0, 0, 0, 0, 1);
      run_to_idle(60, 60, 200, "mix_timeout");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
